// File: rtl/lsu_mem_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_if -- load/store unit between the single-cycle datapath and a
// word-addressed request/grant/response data-memory bus.
//
// An access is sampled from the datapath when IDLE sees lsu_req. It is then
// either rejected at once with lsu_misalign set, or issued on the bus. The
// access completes with a one-cycle lsu_done pulse. lsu_busy stalls the PC
// until that pulse.
//
// Ports
//   clk, nrst        clock, asynchronous active-low reset
//   lsu_req/we       access request (held until lsu_done), 1=store
//   lsu_funct3       LB/LH/LW/LBU/LHU, SB/SH/SW encoding
//   lsu_addr/wdata   byte effective address, store data (rs2)
//   lsu_rdata        extended load data, valid with lsu_done
//   lsu_done         completion pulse
//   lsu_busy         combinational stall (lsu_req & ~lsu_done)
//   lsu_misalign     with lsu_done: misaligned/illegal, no bus access made
//   lsu_bus_err      with lsu_done: bus error response or watchdog timeout
//   bus_req..wdata   registered bus request fields (word address, byte enables)
//   bus_gnt          request accepted
//   bus_rvalid       response valid; bus_rdata/bus_err qualified by it
// -----------------------------------------------------------------------------
module lsu_mem_if #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMER_W        = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic [31:0] lsu_rdata,
  output logic        lsu_done,
  output logic        lsu_busy,
  output logic        lsu_misalign,
  output logic        lsu_bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [2:0]         f3_q;
  logic [1:0]         off_q;

  logic accept, reject, resp, timeout, timer_hit;

  // Misaligned access or funct3 that has no meaning for the direction.
  function automatic logic is_bad(input logic we, input logic [2:0] f3,
                                  input logic [1:0] a);
    logic illegal, misal;
    if (we) illegal = f3[2] | (f3[1:0] == 2'b11);
    else    illegal = (f3[1:0] == 2'b11) | (f3 == 3'b110);
    misal = ((f3[1:0] == 2'b01) & a[0]) | ((f3[1:0] == 2'b10) & (a != 2'b00));
    return illegal | misal;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is replicated across all lanes so the byte enables alone pick it.
  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  assign timer_hit = (TIMEOUT_CYCLES != 0) && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    resp      = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (lsu_req) begin
          accept = 1'b1;
          if (is_bad(lsu_we, lsu_funct3, lsu_addr[1:0])) begin
            reject    = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A same-cycle response wins over the watchdog expiring.
        if (bus_gnt && bus_rvalid) begin
          resp      = 1'b1;
          state_nxt = S_DONE;
        end else if (timer_hit) begin
          timeout   = 1'b1;
          state_nxt = S_DONE;
        end else if (bus_gnt) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          resp      = 1'b1;
          state_nxt = S_DONE;
        end else if (timer_hit) begin
          timeout   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;  // DONE: lsu_req deliberately ignored
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= S_IDLE;
      timer        <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
      lsu_rdata    <= '0;
      lsu_misalign <= 1'b0;
      lsu_bus_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bus_req <= (state_nxt == S_REQ);

      if (accept) begin
        timer <= '0;
        f3_q  <= lsu_funct3;
        off_q <= lsu_addr[1:0];
        if (reject) begin
          lsu_misalign <= 1'b1;
        end else begin
          bus_we    <= lsu_we;
          bus_addr  <= {lsu_addr[31:2], 2'b00};
          bus_be    <= byte_en(lsu_funct3[1:0], lsu_addr[1:0]);
          bus_wdata <= lsu_we ? lane_data(lsu_funct3[1:0], lsu_wdata) : 32'd0;
        end
      end else if (state == S_REQ || state == S_WAIT) begin
        timer <= timer + TIMER_W'(1);
      end

      if (resp) begin
        lsu_bus_err <= bus_err;
        lsu_rdata   <= (bus_err || bus_we) ? 32'd0 : load_ext(f3_q, off_q, bus_rdata);
      end
      if (timeout) begin
        lsu_bus_err <= 1'b1;
        lsu_rdata   <= '0;
      end

      // Status outputs are pulses that live only in DONE.
      if (state == S_DONE) begin
        lsu_rdata    <= '0;
        lsu_misalign <= 1'b0;
        lsu_bus_err  <= 1'b0;
      end
    end
  end

  assign lsu_done = (state == S_DONE);
  assign lsu_busy = lsu_req & ~lsu_done;

endmodule

// File: tb/tb_lsu_mem_if.sv
module tb_lsu_mem_if;

  logic        clk = 1'b0;
  logic        nrst;
  logic        lsu_req, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_done, lsu_busy, lsu_misalign, lsu_bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  lsu_mem_if #(.TIMEOUT_CYCLES(16), .TIMER_W(8)) dut (
    .clk(clk), .nrst(nrst),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .lsu_busy(lsu_busy),
    .lsu_misalign(lsu_misalign), .lsu_bus_err(lsu_bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    int          lat;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vec  = 0;
  int   miss = 0;

  // Observations from the last access.
  int          o_lat;
  logic        o_done, o_req, o_we, o_busy, o_busy_done, o_req_at_done;
  logic        o_mis, o_err;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_be;

  // Drives one access and plays the memory side. gnt_wait: REQ cycles before
  // grant (-1 = never). rv_wait: cycles after grant before rvalid (0 = same
  // cycle as grant). hold: leave lsu_req high and return in the DONE cycle.
  task automatic run_access(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int gnt_wait, input int rv_wait,
                            input logic [31:0] rd, input logic er, input bit hold);
    int rq, wt;
    bit granted;
    rq = 0; wt = 0; granted = 0;
    o_done = 0; o_req = 0; o_lat = -1; o_busy = 0;
    @(negedge clk);
    lsu_req = 1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
    for (int c = 1; c <= 40 && !o_done; c++) begin
      @(posedge clk); #1;
      bus_gnt = 0; bus_rvalid = 0; bus_err = 0; bus_rdata = 32'h0;
      if (lsu_done) begin
        o_done = 1; o_lat = c; o_rdata = lsu_rdata; o_mis = lsu_misalign;
        o_err = lsu_bus_err; o_req_at_done = bus_req; o_busy_done = lsu_busy;
        if (!hold) lsu_req = 0;
      end else if (bus_req) begin
        if (!o_req) begin
          o_req = 1; o_we = bus_we; o_addr = bus_addr; o_be = bus_be;
          o_wdata = bus_wdata; o_busy = lsu_busy;
        end
        if (rq == gnt_wait) begin
          bus_gnt = 1; granted = 1;
          if (rv_wait == 0) begin bus_rvalid = 1; bus_rdata = rd; bus_err = er; end
        end
        rq++;
      end else if (granted) begin
        wt++;
        if (wt == rv_wait) begin bus_rvalid = 1; bus_rdata = rd; bus_err = er; end
      end
    end
    if (!hold) begin
      lsu_req = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    lsu_req = 0; lsu_we = 0; lsu_funct3 = 0; lsu_addr = 0; lsu_wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_err = 0; bus_rdata = 0;
    nrst = 0;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({lsu_done, lsu_busy, lsu_misalign, lsu_bus_err, bus_req, bus_we} !== 6'b0) begin
      miss++;
      $display("FAIL reset_ctrl got %b want 000000",
               {lsu_done, lsu_busy, lsu_misalign, lsu_bus_err, bus_req, bus_we});
    end
    vec++;
    if ({lsu_rdata, bus_addr, bus_be, bus_wdata} !== 100'b0) begin
      miss++;
      $display("FAIL reset_data got rdata=%h addr=%h be=%b wdata=%h want zeros",
               lsu_rdata, bus_addr, bus_be, bus_wdata);
    end
    @(negedge clk); nrst = 1;
  endtask

  task automatic test_load_word();
    sb.push_back('{32'hDEADBEEF, 0, 0, 3, 1, 0, 32'h100, 4'b1111, 32'h0});
    run_access(0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 0, 0);
    e = sb.pop_front();
    vec++;
    if (o_lat !== e.lat) begin miss++; $display("FAIL lw_latency got %0d want %0d", o_lat, e.lat); end
    vec++;
    if (o_rdata !== e.rdata) begin miss++; $display("FAIL lw_rdata got %h want %h", o_rdata, e.rdata); end
    vec++;
    if ({o_req, o_we, o_addr, o_be, o_wdata} !== {e.req, e.we, e.addr, e.be, e.wdata}) begin
      miss++;
      $display("FAIL lw_bus got req=%b we=%b addr=%h be=%b wd=%h want req=%b we=%b addr=%h be=%b wd=%h",
               o_req, o_we, o_addr, o_be, o_wdata, e.req, e.we, e.addr, e.be, e.wdata);
    end
    vec++;
    if ({o_busy, o_busy_done, o_mis, o_err} !== 4'b1000) begin
      miss++;
      $display("FAIL lw_flags got busy/busy_done/mis/err=%b want 1000",
               {o_busy, o_busy_done, o_mis, o_err});
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b001};
    logic [31:0] ads [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
    logic [3:0]  bes [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0011};
    logic [31:0] res [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00008011,
                             32'hFFFF8011, 32'h00002233};
    for (int i = 0; i < 5; i++) begin
      // alternate typical and minimum latency
      sb.push_back('{res[i], 0, 0, (i % 2 == 0) ? 3 : 2, 1, 0, 32'h100, bes[i], 32'h0});
      run_access(0, f3s[i], ads[i], 32'h0, 0, (i % 2 == 0) ? 1 : 0, 32'h80112233, 0, 0);
      e = sb.pop_front();
      vec++;
      if ({o_lat, o_rdata} !== {e.lat, e.rdata}) begin
        miss++;
        $display("FAIL ld_ext[%0d] got lat=%0d rdata=%h want lat=%0d rdata=%h",
                 i, o_lat, o_rdata, e.lat, e.rdata);
      end
      vec++;
      if ({o_addr, o_be, o_we} !== {e.addr, e.be, e.we}) begin
        miss++;
        $display("FAIL ld_bus[%0d] got addr=%h be=%b we=%b want addr=%h be=%b we=%b",
                 i, o_addr, o_be, o_we, e.addr, e.be, e.we);
      end
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3s [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] ads [3] = '{32'h201, 32'h202, 32'h204};
    logic [31:0] wds [3] = '{32'h000000A5, 32'h1234ABCD, 32'hCAFEF00D};
    logic [3:0]  bes [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] bws [3] = '{32'hA5A5A5A5, 32'hABCDABCD, 32'hCAFEF00D};
    logic [31:0] bad [3] = '{32'h200, 32'h200, 32'h204};
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{32'h0, 0, 0, 3, 1, 1, bad[i], bes[i], bws[i]});
      run_access(1, f3s[i], ads[i], wds[i], 0, 1, 32'hFFFFFFFF, 0, 0);
      e = sb.pop_front();
      vec++;
      if ({o_we, o_addr, o_be, o_wdata} !== {e.we, e.addr, e.be, e.wdata}) begin
        miss++;
        $display("FAIL st_bus[%0d] got we=%b addr=%h be=%b wd=%h want we=%b addr=%h be=%b wd=%h",
                 i, o_we, o_addr, o_be, o_wdata, e.we, e.addr, e.be, e.wdata);
      end
      vec++;
      if ({o_lat, o_rdata, o_mis, o_err} !== {e.lat, e.rdata, e.mis, e.err}) begin
        miss++;
        $display("FAIL st_done[%0d] got lat=%0d rdata=%h mis=%b err=%b want lat=%0d rdata=%h mis=%b err=%b",
                 i, o_lat, o_rdata, o_mis, o_err, e.lat, e.rdata, e.mis, e.err);
      end
    end
  endtask

  task automatic test_misalign();
    logic        wes [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s [4] = '{3'b010, 3'b011, 3'b001, 3'b011};
    logic [31:0] ads [4] = '{32'h102, 32'h100, 32'h101, 32'h100};
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{32'h0, 1, 0, 1, 0, 0, 32'h0, 4'h0, 32'h0});
      run_access(wes[i], f3s[i], ads[i], 32'h55, 0, 0, 32'h12345678, 0, 0);
      e = sb.pop_front();
      vec++;
      if ({o_lat, o_mis, o_err, o_req, o_rdata} !== {e.lat, e.mis, e.err, e.req, e.rdata}) begin
        miss++;
        $display("FAIL misalign[%0d] got lat=%0d mis=%b err=%b req=%b rdata=%h want lat=%0d mis=%b err=%b req=%b rdata=%h",
                 i, o_lat, o_mis, o_err, o_req, o_rdata, e.lat, e.mis, e.err, e.req, e.rdata);
      end
    end
  endtask

  task automatic test_bus_error();
    sb.push_back('{32'h0, 0, 1, 17, 1, 0, 32'h0, 4'h0, 32'h0});
    run_access(0, 3'b010, 32'h400, 32'h0, -1, 0, 32'h0, 0, 0);
    e = sb.pop_front();
    vec++;
    if ({o_lat, o_err, o_mis, o_req_at_done, o_rdata} !== {e.lat, e.err, e.mis, 1'b0, e.rdata}) begin
      miss++;
      $display("FAIL timeout got lat=%0d err=%b mis=%b req=%b rdata=%h want lat=%0d err=1 mis=0 req=0 rdata=0",
               o_lat, o_err, o_mis, o_req_at_done, o_rdata, e.lat);
    end
    sb.push_back('{32'h0, 0, 1, 3, 1, 0, 32'h0, 4'h0, 32'h0});
    run_access(0, 3'b010, 32'h404, 32'h0, 0, 1, 32'h12345678, 1, 0);
    e = sb.pop_front();
    vec++;
    if ({o_lat, o_err, o_mis, o_rdata} !== {e.lat, e.err, e.mis, e.rdata}) begin
      miss++;
      $display("FAIL rsp_err got lat=%0d err=%b mis=%b rdata=%h want lat=%0d err=1 mis=0 rdata=0",
               o_lat, o_err, o_mis, o_rdata, e.lat);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    @(negedge clk);
    lsu_req = 1; lsu_we = 0; lsu_funct3 = 3'b010; lsu_addr = 32'h100;
    @(posedge clk); #1;            // REQ
    bus_gnt = 1;
    @(posedge clk); #1;            // WAIT
    bus_gnt = 0;
    #2;
    lsu_req = 0;
    nrst = 0;
    #1;
    vec++;
    if ({lsu_done, lsu_misalign, lsu_bus_err, bus_req, bus_we, bus_be, bus_addr, lsu_rdata} !== 73'b0) begin
      miss++;
      $display("FAIL reset_mid got done=%b req=%b be=%b addr=%h want all zero",
               lsu_done, bus_req, bus_be, bus_addr);
    end
    @(negedge clk); nrst = 1;
    bus_rvalid = 1; bus_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (lsu_done) dones++;
    end
    bus_rvalid = 0; bus_rdata = 0;
    vec++;
    if (dones !== 0) begin miss++; $display("FAIL reset_late_rvalid got %0d dones want 0", dones); end
  endtask

  task automatic test_back_to_back();
    sb.push_back('{32'h0000BEEF, 0, 0, 2, 1, 0, 32'h300, 4'b0011, 32'h0});
    sb.push_back('{32'hFFFFFF99, 0, 0, 3, 1, 0, 32'h304, 4'b0100, 32'h0});
    run_access(0, 3'b101, 32'h300, 32'h0, 0, 0, 32'h1234BEEF, 0, 1);
    e = sb.pop_front();
    vec++;
    if ({o_lat, o_rdata} !== {e.lat, e.rdata}) begin
      miss++;
      $display("FAIL b2b_first got lat=%0d rdata=%h want lat=%0d rdata=%h", o_lat, o_rdata, e.lat, e.rdata);
    end
    // issued during DONE: one extra cycle through IDLE before acceptance
    run_access(0, 3'b000, 32'h306, 32'h0, 0, 0, 32'h00990000, 0, 0);
    e = sb.pop_front();
    vec++;
    if ({o_lat, o_rdata, o_addr, o_be} !== {e.lat, e.rdata, e.addr, e.be}) begin
      miss++;
      $display("FAIL b2b_second got lat=%0d rdata=%h addr=%h be=%b want lat=%0d rdata=%h addr=%h be=%b",
               o_lat, o_rdata, o_addr, o_be, e.lat, e.rdata, e.addr, e.be);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_store();
    test_misalign();
    test_bus_error();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
Load/store unit directly downstream of the single-cycle datapath. It consumes the effective address (ALU output), rs2 store data and funct3. It drives a word-addressed request/grant/response data-memory bus with byte enables. It returns aligned, sign/zero-extended load data for write-back and stalls the PC (pc_wren) until the access completes.

Parameters:
TIMEOUT_CYCLES, 16, cycles allowed in REQ+WAIT before aborting with bus error; 0 disables watchdog
TIMER_W, 8, width of watchdog counter (must hold TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock, all state on rising edge
nrst  input  1  asynchronous active-low reset
lsu_req  input  1  load/store requested; held by control until lsu_done
lsu_we  input  1  1=store, 0=load
lsu_funct3  input  3  inst_funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
lsu_addr  input  32  byte effective address (alu_out)
lsu_wdata  input  32  store data (rs2)
lsu_rdata  output  32  extended load data, valid when lsu_done
lsu_done  output  1  one-cycle completion pulse
lsu_busy  output  1  combinational stall = lsu_req & ~lsu_done
lsu_misalign  output  1  pulse with lsu_done: misaligned or illegal funct3, no bus access
lsu_bus_err  output  1  pulse with lsu_done: bus_err or timeout
bus_req  output  1  request, held until bus_gnt
bus_we  output  1  write strobe
bus_addr  output  32  word address {lsu_addr[31:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_gnt  input  1  request accepted this cycle
bus_rvalid  input  1  response valid (loads and stores)
bus_rdata  input  32  read word
bus_err  input  1  error, qualified by bus_rvalid

Behaviour:
- Reset (async, nrst=0): state IDLE; every output 0; watchdog cleared. Mid-access reset drops bus_req immediately; any response after reset is ignored in IDLE.
- States: IDLE, REQ, WAIT, DONE. bus_* outputs are registered, captured at acceptance, stable through REQ.
- IDLE: lsu_req=1 samples inputs. Aligned and legal -> REQ. Misaligned or illegal -> DONE with lsu_misalign=1.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0. Illegal: load funct3 011/110/111; store funct3 other than 000/001/010.
- REQ: bus_req=1. bus_gnt=1 -> WAIT. If bus_gnt and bus_rvalid are both 1 -> DONE directly.
- WAIT: bus_req=0. bus_rvalid=1 -> DONE.
- DONE: lsu_done=1 for exactly one cycle; lsu_req ignored -> IDLE. The PC advances on this edge, so no retrigger occurs.
- Minimum latency: accept at t0, done at t2 (gnt+rvalid same cycle); typical t3.
- Store enables and data:
  - SB: bus_be = 4'b0001<<addr[1:0]; bus_wdata = {4{wdata[7:0]}}
  - SH: bus_be = addr[1] ? 1100 : 0011; bus_wdata = {2{wdata[15:0]}}
  - SW: bus_be = 1111; bus_wdata = wdata
- Load enables: bus_be per the same size rules; bus_wdata=0.
- Load data: byte/half selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. Registered on the rvalid edge.
- lsu_rdata=0 for stores, misalign, or error.
- bus_err=1 with bus_rvalid -> lsu_bus_err=1 in DONE.
- Watchdog: counts REQ+WAIT cycles. On reaching TIMEOUT_CYCLES -> DONE with lsu_bus_err=1, bus_req dropped; any late rvalid is ignored.
- lsu_misalign and lsu_bus_err are never both 1.

Test Plan:
- LW addr 0x100, gnt in first REQ, rvalid next cycle rdata 0xDEADBEEF -> bus_addr 0x100, be 1111, lsu_done at t3, lsu_rdata 0xDEADBEEF.
- LB addr 0x103, rdata 0x80112233 -> be 1000, lsu_rdata 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
- SB addr 0x201 wdata 0x000000A5 -> bus_we 1, be 0010, wdata 0xA5A5A5A5; SH addr 0x202 -> be 1100, wdata {2{low half}}.
- LW addr 0x102 -> no bus_req; lsu_done+lsu_misalign at t1; funct3 011 load -> same response.
- bus_gnt held 0 for 16 cycles -> lsu_done+lsu_bus_err, bus_req 0. Separately, rvalid with bus_err=1 -> lsu_bus_err, rdata 0.
- nrst pulsed during WAIT -> outputs 0 immediately; later rvalid produces no lsu_done. Back-to-back lsu_req after DONE -> new access accepted in IDLE.
